// File: rtl/rf_write_arbiter_if.sv
// Writeback request bundle and RF write port for rf_write_arbiter.
// RF_WB_FORWARD_EN adds the decode-stage forwarding compare signals.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              regWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              busy;
`ifdef RF_WB_FORWARD_EN
  logic [ADDR_W-1:0] fwd_reg_1;
  logic [ADDR_W-1:0] fwd_reg_2;
  logic              fwd_hit_1;
  logic              fwd_hit_2;

  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    input  fwd_reg_1, fwd_reg_2,
    output a_ready, b_ready,
    output regWrite, write_reg, write_data,
    output busy, fwd_hit_1, fwd_hit_2
  );

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    output fwd_reg_1, fwd_reg_2,
    input  a_ready, b_ready,
    input  regWrite, write_reg, write_data,
    input  busy, fwd_hit_1, fwd_hit_2
  );
`else
  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    output a_ready, b_ready,
    output regWrite, write_reg, write_data,
    output busy
  );

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    input  a_ready, b_ready,
    input  regWrite, write_reg, write_data,
    input  busy
  );
`endif
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter (ALU / load writeback).
// Optional RF_WB_FORWARD_EN adds write-port forwarding hit compares.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit RR_EN  = 1'b1
) (
  input logic clk,
  input logic rst_n,
  rf_write_arbiter_if.slave bus
);

  logic              gnt_a;
  logic              gnt_b;
  logic              last_b_q, last_b_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // A wins a tie when B had the last grant, or always without round-robin
  always_comb begin
    gnt_a = bus.a_valid &
            (~bus.b_valid | (RR_EN == 1'b0) | last_b_q);
    gnt_b = bus.b_valid & ~gnt_a;
  end

  always_comb begin
    last_b_d  = last_b_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    unique case (1'b1)
      gnt_a: begin
        last_b_d = 1'b0;
        if (bus.a_reg != '0) begin
          wr_en_d   = 1'b1;
          wr_reg_d  = bus.a_reg;
          wr_data_d = bus.a_data;
        end
      end
      gnt_b: begin
        last_b_d = 1'b1;
        if (bus.b_reg != '0) begin
          wr_en_d   = 1'b1;
          wr_reg_d  = bus.b_reg;
          wr_data_d = bus.b_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q  <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      last_b_q  <= last_b_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.a_ready    = gnt_a;
  assign bus.b_ready    = gnt_b;
  assign bus.regWrite   = wr_en_q;
  assign bus.write_reg  = wr_reg_q;
  assign bus.write_data = wr_data_q;
  assign bus.busy       = wr_en_q | bus.a_valid | bus.b_valid;

`ifdef RF_WB_FORWARD_EN
  assign bus.fwd_hit_1 = wr_en_q & (wr_reg_q == bus.fwd_reg_1) &
                         (bus.fwd_reg_1 != '0);
  assign bus.fwd_hit_2 = wr_en_q & (wr_reg_q == bus.fwd_reg_2) &
                         (bus.fwd_reg_2 != '0);
`endif

endmodule
